// File: rtl/palette_dac_ctrl.sv
// palette_dac_ctrl: VGA-DAC style sequencer for a 256 x 12-bit color palette.
// Software sets a start index, then streams R, G, B bytes. Each complete triple
// becomes a pending entry. The entry is pushed out through the palette write
// port, either immediately or only while the display is blanked.
module palette_dac_ctrl #(
  parameter int DEFER_TO_BLANK = 1,  // 1: commit only while blank is high
  parameter int COMP_LSB       = 2   // bit position of the 4-bit component in bus_wdata (0..4)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ready,
  input  logic       blank,
  output logic       pal_we,
  output logic [7:0] pal_index,
  output logic [3:0] pal_r,
  output logic [3:0] pal_g,
  output logic [3:0] pal_b
);

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  localparam logic [1:0] A_INDEX  = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;

  logic [1:0]  phase_reg;
  logic [1:0]  phase_next;
  logic [7:0]  wr_index_reg;
  logic [3:0]  r_hold_reg;
  logic [3:0]  g_hold_reg;
  logic        pend_valid_reg;
  logic [7:0]  pend_index_reg;
  logic [11:0] pend_rgb_reg;

  logic [3:0]  comp;
  logic        commit_fire;
  logic        data_wr_req;
  logic        accept;
  logic        idx_wr;
  logic        data_wr;
  logic        ld_r;
  logic        ld_g;
  logic        ld_b;

  assign comp = bus_wdata[COMP_LSB+3:COMP_LSB];

  // The pending entry leaves when blanking allows it (or always when not deferring).
  assign commit_fire = pend_valid_reg & ((DEFER_TO_BLANK == 0) | blank);

  // Only the blue byte can stall: it needs the pending slot, which must be
  // free or draining in this very cycle.
  assign data_wr_req = bus_sel & bus_we & (bus_addr == A_DATA);
  assign bus_ready   = ~(data_wr_req & (phase_reg == PH_B) & pend_valid_reg & ~commit_fire);

  assign accept  = bus_sel & bus_ready;
  assign idx_wr  = accept & bus_we & (bus_addr == A_INDEX);
  assign data_wr = accept & bus_we & (bus_addr == A_DATA);

  // Component phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= PH_R;
    end else begin
      phase_reg <= phase_next;
    end
  end

  // Phase advance: index writes restart the triple, data writes step R->G->B->R.
  always_comb begin
    phase_next = phase_reg;
    if (idx_wr) begin
      phase_next = PH_R;
    end else if (data_wr) begin
      case (phase_reg)
        PH_R:    phase_next = PH_G;
        PH_G:    phase_next = PH_B;
        default: phase_next = PH_R;
      endcase
    end
  end

  // Phase decode into per-component load strobes.
  always_comb begin
    ld_r = 1'b0;
    ld_g = 1'b0;
    ld_b = 1'b0;
    if (data_wr) begin
      case (phase_reg)
        PH_R:    ld_r = 1'b1;
        PH_G:    ld_g = 1'b1;
        default: ld_b = 1'b1;
      endcase
    end
  end

  // Triple assembly, index auto-increment and the one-deep pending buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_index_reg   <= 8'h00;
      r_hold_reg     <= 4'h0;
      g_hold_reg     <= 4'h0;
      pend_valid_reg <= 1'b0;
      pend_index_reg <= 8'h00;
      pend_rgb_reg   <= 12'h000;
    end else begin
      if (idx_wr) begin
        wr_index_reg <= bus_wdata;
      end else if (ld_b) begin
        wr_index_reg <= wr_index_reg + 8'd1;
      end
      if (ld_r) begin
        r_hold_reg <= comp;
      end
      if (ld_g) begin
        g_hold_reg <= comp;
      end
      if (ld_b) begin
        pend_index_reg <= wr_index_reg;
        pend_rgb_reg   <= {r_hold_reg, g_hold_reg, comp};
      end
      // A refill in the same cycle as a commit keeps the slot occupied.
      if (ld_b) begin
        pend_valid_reg <= 1'b1;
      end else if (commit_fire) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  // Commit stage: registered palette write port with a one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pal_we    <= 1'b0;
      pal_index <= 8'h00;
      pal_r     <= 4'h0;
      pal_g     <= 4'h0;
      pal_b     <= 4'h0;
    end else begin
      pal_we <= commit_fire;
      if (commit_fire) begin
        pal_index <= pend_index_reg;
        pal_r     <= pend_rgb_reg[11:8];
        pal_g     <= pend_rgb_reg[7:4];
        pal_b     <= pend_rgb_reg[3:0];
      end
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      A_INDEX:  bus_rdata = wr_index_reg;
      A_STATUS: bus_rdata = {3'b000, pend_valid_reg, blank,
                             pend_valid_reg & ~commit_fire, phase_reg};
      default:  bus_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_palette_dac_ctrl.sv
// tb_palette_dac_ctrl: directed checks of palette_dac_ctrl with one undeferred
// and one blank-deferred instance sharing clock, reset and bus payload.
module tb_palette_dac_ctrl;

  logic       clk;
  logic       reset;
  logic       sel0, sel1;
  logic       bus_we;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       blank;

  logic [7:0] rdata0, rdata1;
  logic       ready0, ready1;
  logic       pal_we0, pal_we1;
  logic [7:0] pal_index0, pal_index1;
  logic [3:0] pal_r0, pal_g0, pal_b0, pal_r1, pal_g1, pal_b1;

  int tests = 0;
  int fails = 0;

  logic [19:0] q0[$];
  logic [19:0] q1[$];

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  palette_dac_ctrl #(.DEFER_TO_BLANK(0), .COMP_LSB(2)) dut0 (
    .clk(clk), .reset(reset), .bus_sel(sel0), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata0), .bus_ready(ready0), .blank(blank),
    .pal_we(pal_we0), .pal_index(pal_index0), .pal_r(pal_r0), .pal_g(pal_g0), .pal_b(pal_b0)
  );

  palette_dac_ctrl #(.DEFER_TO_BLANK(1), .COMP_LSB(2)) dut1 (
    .clk(clk), .reset(reset), .bus_sel(sel1), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata1), .bus_ready(ready1), .blank(blank),
    .pal_we(pal_we1), .pal_index(pal_index1), .pal_r(pal_r1), .pal_g(pal_g1), .pal_b(pal_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every palette write strobe from each instance.
  always @(negedge clk) begin
    if (pal_we0) q0.push_back({pal_index0, pal_r0, pal_g0, pal_b0});
    if (pal_we1) q1.push_back({pal_index1, pal_r1, pal_g1, pal_b1});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s ok (%0h)", name, act);
    end
  endtask

  // Single bus transfer; called at #1 after a rising edge, returns likewise.
  task automatic bus_op(input int which, input logic we, input logic [1:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata);
    int   n;
    logic rdy;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    if (which == 0) sel0 = 1'b1; else sel1 = 1'b1;
    n = 0;
    rdy = 1'b0;
    rdata = 8'h00;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy   = (which == 0) ? ready0 : ready1;
      rdata = (which == 0) ? rdata0 : rdata1;
      @(posedge clk);
      #1;
      n++;
    end
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL bus_timeout: dut%0d addr %0d not ready after %0d cycles", which, addr, n);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                     input logic [7:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.exp = exp;
    tbl.push_back(v);
  endtask

  logic [7:0] rd;

  initial begin
    reset = 1'b1; sel0 = 1'b0; sel1 = 1'b0; bus_we = 1'b0;
    bus_addr = 2'd0; bus_wdata = 8'h00; blank = 1'b0;

    // Interleaved read/write vectors for the undeferred instance, starting at index 8'h11.
    add(0, 2'd0, 8'h00, 8'h11);
    add(0, 2'd2, 8'h00, 8'h00);
    add(1, 2'd1, 8'h04, 8'h00);   // R = 1 (abandoned)
    add(0, 2'd2, 8'h00, 8'h01);
    add(1, 2'd1, 8'h08, 8'h00);   // G = 2 (abandoned)
    add(0, 2'd2, 8'h00, 8'h02);
    add(1, 2'd0, 8'h40, 8'h00);   // restart at 8'h40
    add(0, 2'd2, 8'h00, 8'h00);
    add(0, 2'd0, 8'h00, 8'h40);
    add(1, 2'd1, 8'h0C, 8'h00);   // R = 3
    add(0, 2'd2, 8'h00, 8'h01);
    add(1, 2'd1, 8'h10, 8'h00);   // G = 4
    add(0, 2'd2, 8'h00, 8'h02);
    add(1, 2'd1, 8'h14, 8'h00);   // B = 5
    add(0, 2'd2, 8'h00, 8'h10);   // pending and committing this cycle
    add(0, 2'd0, 8'h00, 8'h41);
    add(0, 2'd2, 8'h00, 8'h00);
    add(0, 2'd1, 8'h00, 8'h00);
    add(0, 2'd3, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    bus_op(0, 0, 2'd0, 8'h00, rd); chk("rst_idx0", rd, 8'h00);
    bus_op(0, 0, 2'd2, 8'h00, rd); chk("rst_stat0", rd, 8'h00);
    bus_op(1, 0, 2'd0, 8'h00, rd); chk("rst_idx1", rd, 8'h00);
    bus_op(1, 0, 2'd2, 8'h00, rd); chk("rst_stat1", rd, 8'h00);
    repeat (20) @(posedge clk);
    #1 chk("rst_no_pulses", q0.size() + q1.size(), 0);

    // Undeferred commit latency and content.
    bus_op(0, 1, 2'd0, 8'h10, rd);
    bus_op(0, 1, 2'd1, 8'h28, rd);
    bus_op(0, 1, 2'd1, 8'h14, rd);
    bus_op(0, 1, 2'd1, 8'h3C, rd);
    @(negedge clk); chk("lat_we_n1", pal_we0, 1'b0);
    @(negedge clk); chk("lat_we_n2", pal_we0, 1'b1);
    chk("lat_entry", {pal_index0, pal_r0, pal_g0, pal_b0}, {8'h10, 4'hA, 4'h5, 4'hF});
    @(negedge clk); chk("lat_we_n3", pal_we0, 1'b0);
    @(posedge clk); #1;

    // Table-driven interleaved reads, index restart mid-triple.
    for (int i = 0; i < tbl.size(); i++) begin
      bus_op(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (!tbl[i].we) chk($sformatf("vec%0d_rd_a%0d", i, tbl[i].addr), rd, tbl[i].exp);
    end
    repeat (2) @(posedge clk);
    #1 chk("dut0_pulses", q0.size(), 2);
    if (q0.size() == 2) begin
      chk("dut0_entry0", q0[0], {8'h10, 4'hA, 4'h5, 4'hF});
      chk("dut0_entry1", q0[1], {8'h40, 4'h3, 4'h4, 4'h5});
    end

    // Deferred: two triples from 8'hFF with blank low; second blue byte stalls.
    bus_op(1, 1, 2'd0, 8'hFF, rd);
    bus_op(1, 1, 2'd1, 8'h04, rd);
    bus_op(1, 1, 2'd1, 8'h08, rd);
    bus_op(1, 1, 2'd1, 8'h0C, rd);
    bus_op(1, 1, 2'd1, 8'h10, rd);
    bus_op(1, 1, 2'd1, 8'h14, rd);
    bus_op(1, 0, 2'd2, 8'h00, rd); chk("defer_stat", rd, 8'h16);
    chk("defer_no_pulse", q1.size(), 0);
    bus_we = 1'b1; bus_addr = 2'd1; bus_wdata = 8'h18; sel1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("stall_ready_%0d", i), ready1, 1'b0);
    end
    @(posedge clk); #1 blank = 1'b1;
    @(negedge clk); chk("stall_release", ready1, 1'b1);
    @(posedge clk); #1 sel1 = 1'b0;
    @(negedge clk);
    chk("defer_p1_we", pal_we1, 1'b1);
    chk("defer_p1", {pal_index1, pal_r1, pal_g1, pal_b1}, {8'hFF, 4'h1, 4'h2, 4'h3});
    @(negedge clk);
    chk("defer_p2_we", pal_we1, 1'b1);
    chk("defer_p2", {pal_index1, pal_r1, pal_g1, pal_b1}, {8'h00, 4'h4, 4'h5, 4'h6});
    @(negedge clk); chk("defer_p3_we", pal_we1, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("defer_pulses", q1.size(), 2);
    bus_op(1, 0, 2'd0, 8'h00, rd); chk("defer_idx", rd, 8'h01);
    blank = 1'b0;

    // Reset while an entry is pending discards it.
    bus_op(1, 1, 2'd0, 8'h20, rd);
    bus_op(1, 1, 2'd1, 8'h04, rd);
    bus_op(1, 1, 2'd1, 8'h04, rd);
    bus_op(1, 1, 2'd1, 8'h04, rd);
    bus_op(1, 0, 2'd2, 8'h00, rd); chk("pend_stat", rd, 8'h14);
    bus_we = 1'b0; bus_addr = 2'd2; sel1 = 1'b1;
    reset = 1'b1;
    #1 chk("async_rst_stat", rdata1, 8'h00);
    sel1 = 1'b0;
    @(posedge clk); #1 reset = 1'b0; blank = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rst_drop_pulses", q1.size(), 2);
    chk("rst_drop_pulses0", q0.size(), 2);
    blank = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
